// File: rtl/pulse_sync_pkg.sv
// Shared defaults and helpers for the multi-channel pulse synchroniser receiver.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package pulse_sync_pkg;

    localparam int PSYNC_CH_DEF     = 4;
    localparam int PSYNC_STAGES_DEF = 2;
    localparam int PSYNC_CNT_W_DEF  = 3;

    // Width of a channel index; never narrower than one bit so a single
    // channel build still has a legal evt_ch port.
    function automatic int psync_idx_w(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/pulse_sync_chain.sv
// One channel: SYNC_STAGES-deep synchroniser, previous-level flop and toggle edge detect.
// Latency: toggle sampled at edge 1 shows on edge_det after edge SYNC_STAGES; lvl follows one edge later.
// Backpressure: none; pulse_en=0 freezes every flop so the toggle level is simply picked up later.
module pulse_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_b,
    input  logic rst_n_b,
    input  logic pulse_en,
    input  logic tgl,
    output logic lvl,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the async level through the synchroniser and remember the last settled level.
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            sync <= '0;
            prev <= 1'b0;
        end else if (pulse_en) begin
            sync <= {sync[SYNC_STAGES-2:0], tgl};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign lvl      = prev;
    assign edge_det = sync[SYNC_STAGES-1] ^ prev;

endmodule

// File: rtl/pulse_sync_rx_mc.sv
// Multi-channel toggle-pulse receiver: sync + edge detect, per-channel pending counters, round-robin event port.
// Latency: toggle at edge 1 -> counted at edge S+1 (ack flips), earliest evt_vld after edge S+2; 1 event/cycle sustained.
// Backpressure: evt_vld & ~evt_rdy holds evt_ch with no grant; events queue in saturating counters (PSYNC_OVF_EN adds sticky ovf).
module pulse_sync_rx_mc
    import pulse_sync_pkg::*;
#(
    parameter int CH          = PSYNC_CH_DEF,
    parameter int SYNC_STAGES = PSYNC_STAGES_DEF,
    parameter int CNT_W       = PSYNC_CNT_W_DEF,
    localparam int IDX_W      = psync_idx_w(CH)
) (
    input  logic             clk_b,
    input  logic             rst_n_b,
    input  logic             pulse_en,
    input  logic [CH-1:0]    tgl_in,
    output logic [CH-1:0]    ack_tgl,
    output logic             evt_vld,
    input  logic             evt_rdy,
    output logic [IDX_W-1:0] evt_ch
`ifdef PSYNC_OVF_EN
    ,
    output logic [CH-1:0]    ovf,
    input  logic [CH-1:0]    ovf_clr
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CH-1:0]    edge_det;
    logic [CNT_W-1:0] cnt [CH];
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] rr_nxt;
    logic             found;
    logic             load;
    logic [CH-1:0]    gnt;

    for (genvar g = 0; g < CH; g++) begin : g_chain
        pulse_sync_chain #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chain (
            .clk_b    (clk_b),
            .rst_n_b  (rst_n_b),
            .pulse_en (pulse_en),
            .tgl      (tgl_in[g]),
            .lvl      (ack_tgl[g]),
            .edge_det (edge_det[g])
        );
    end

    // Round-robin search: first channel with pending events at or above the rr pointer, wrapping mod CH.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < CH; k++) begin
            j = (int'(rr) + k) % CH;
            if (!found && cnt[j] != '0) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    // The output register refills when empty or being consumed; a frozen block grants nothing.
    always_comb begin
        load   = pulse_en && (!evt_vld || evt_rdy);
        rr_nxt = (win == IDX_W'(CH - 1)) ? '0 : win + IDX_W'(1);
        gnt    = '0;
        if (load && found) begin
            gnt[win] = 1'b1;
        end
    end

    // Pending counters: simultaneous edge and grant cancel out; an edge into a full counter is dropped.
    always_ff @(posedge clk_b) begin
        for (int i = 0; i < CH; i++) begin
            if (!rst_n_b) begin
                cnt[i] <= '0;
            end else if (pulse_en) begin
                if (edge_det[i] && !gnt[i]) begin
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else if (gnt[i] && !edge_det[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Event output register and round-robin pointer; evt_ch keeps its last value when nothing is pending.
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            evt_vld <= 1'b0;
            evt_ch  <= '0;
            rr      <= '0;
        end else if (load) begin
            if (found) begin
                evt_vld <= 1'b1;
                evt_ch  <= win;
                rr      <= rr_nxt;
            end else begin
                evt_vld <= 1'b0;
            end
        end
    end

`ifdef PSYNC_OVF_EN
    logic [CH-1:0] drop;

    // A drop is an un-cancelled edge arriving at a saturated counter.
    always_comb begin
        drop = '0;
        for (int i = 0; i < CH; i++) begin
            drop[i] = edge_det[i] && !gnt[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Sticky overflow flags; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk_b) begin
        if (!rst_n_b) begin
            ovf <= '0;
        end else if (pulse_en) begin
            ovf <= (ovf & ~ovf_clr) | drop;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_sync_rx_mc.sv
// Self-checking bench for pulse_sync_rx_mc (CH=4, SYNC_STAGES=2, CNT_W=3).
// Directed steps for reset, latency, round-robin, stall/saturation, freeze and cancel; then a random run.
// Random run compares delivered events per channel against toggles issued by a source model.
module tb_pulse_sync_rx_mc;

    localparam int CH = 4;

    logic       clk_b = 1'b0;
    logic       rst_n_b;
    logic       pulse_en;
    logic [3:0] tgl_in;
    logic [3:0] ack_tgl;
    logic       evt_vld;
    logic       evt_rdy;
    logic [1:0] evt_ch;
`ifdef PSYNC_OVF_EN
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] tg;

    always #5 clk_b = ~clk_b;

    pulse_sync_rx_mc #(
        .CH(4),
        .SYNC_STAGES(2),
        .CNT_W(3)
    ) dut (
        .clk_b    (clk_b),
        .rst_n_b  (rst_n_b),
        .pulse_en (pulse_en),
        .tgl_in   (tgl_in),
        .ack_tgl  (ack_tgl),
        .evt_vld  (evt_vld),
        .evt_rdy  (evt_rdy),
        .evt_ch   (evt_ch)
`ifdef PSYNC_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_b);
        #1;
    endtask

    task automatic flip(input int c);
        tg[c]  = ~tg[c];
        tgl_in = tg;
    endtask

    initial begin
        int issued    [CH];
        int delivered [CH];
        int total_iss;
        int total_del;
        int cyc;
        int n_ev;
        logic bad_ch;

        // ---------------- reset ----------------
        rst_n_b  = 1'b0;
        pulse_en = 1'b1;
        evt_rdy  = 1'b1;
        tg       = 4'hF;
        tgl_in   = tg;
`ifdef PSYNC_OVF_EN
        ovf_clr  = 4'h0;
`endif
        tick(3);
        chk("rst_ack", 32'(ack_tgl), 32'h0);
        chk("rst_vld", 32'(evt_vld), 32'h0);
        chk("rst_ch", 32'(evt_ch), 32'h0);
`ifdef PSYNC_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'h0);
`endif
        rst_n_b = 1'b1;
        tick(2);
        chk("rel_ack_e2", 32'(ack_tgl), 32'h0);
        tick(1);
        chk("rel_ack_e3", 32'(ack_tgl), 32'hF);
        chk("rel_vld_e3", 32'(evt_vld), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk("rel_seq_vld", 32'(evt_vld), 32'h1);
            chk("rel_seq_ch", 32'(evt_ch), 32'(c));
        end
        tick(1);
        chk("rel_done", 32'(evt_vld), 32'h0);

        // ---------------- latency on ch2 ----------------
        flip(2);
        tick(2);
        chk("lat_ack_e2", 32'(ack_tgl), 32'hF);
        tick(1);
        chk("lat_ack_e3", 32'(ack_tgl), 32'hB);
        chk("lat_vld_e3", 32'(evt_vld), 32'h0);
        tick(1);
        chk("lat_vld_e4", 32'(evt_vld), 32'h1);
        chk("lat_ch_e4", 32'(evt_ch), 32'h2);
        tick(1);
        chk("lat_vld_e5", 32'(evt_vld), 32'h0);

        // ---------------- round robin: held ch0, then ch1 x2 and ch3 x1 pending ----------------
        evt_rdy = 1'b0;
        flip(0);
        tick(5);
        flip(1);
        flip(3);
        tick(2);
        flip(1);
        tick(6);
        chk("rr_hold_vld", 32'(evt_vld), 32'h1);
        chk("rr_hold_ch", 32'(evt_ch), 32'h0);
        evt_rdy = 1'b1;
        tick(1);
        chk("rr_ev1", 32'(evt_ch), 32'h1);
        tick(1);
        chk("rr_ev2", 32'(evt_ch), 32'h3);
        tick(1);
        chk("rr_ev3", 32'(evt_ch), 32'h1);
        chk("rr_ev3_vld", 32'(evt_vld), 32'h1);
        tick(1);
        chk("rr_done", 32'(evt_vld), 32'h0);

        // ---------------- stall / saturation on ch0 ----------------
        evt_rdy = 1'b0;
        for (int t = 0; t < 9; t++) begin
            flip(0);
            tick(2);
        end
        tick(6);
        chk("sat_hold_vld", 32'(evt_vld), 32'h1);
        chk("sat_hold_ch", 32'(evt_ch), 32'h0);
`ifdef PSYNC_OVF_EN
        chk("sat_ovf", 32'(ovf), 32'h1);
        ovf_clr = 4'h1;
        tick(1);
        ovf_clr = 4'h0;
        chk("sat_ovf_clr", 32'(ovf), 32'h0);
`endif
        evt_rdy = 1'b1;
        n_ev    = 0;
        bad_ch  = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (evt_vld) begin
                n_ev++;
                if (evt_ch != 2'd0) bad_ch = 1'b1;
            end
            tick(1);
        end
        chk("sat_events", 32'(n_ev), 32'd8);
        chk("sat_all_ch0", 32'(bad_ch), 32'h0);

        // ---------------- freeze during a ch1 toggle ----------------
        pulse_en = 1'b0;
        flip(1);
        tick(10);
        chk("frz_ack", 32'(ack_tgl), 32'(~tg & 4'h2 ^ tg));
        chk("frz_vld", 32'(evt_vld), 32'h0);
        pulse_en = 1'b1;
        tick(3);
        chk("frz_ack_after", 32'(ack_tgl), 32'(tg));
        chk("frz_vld_e3", 32'(evt_vld), 32'h0);
        tick(1);
        chk("frz_vld_e4", 32'(evt_vld), 32'h1);
        chk("frz_ch_e4", 32'(evt_ch), 32'h1);
        n_ev = 0;
        for (int t = 0; t < 8; t++) begin
            tick(1);
            if (evt_vld) n_ev++;
        end
        chk("frz_once", 32'(n_ev), 32'h0);

        // ---------------- ch0 edge in the same cycle as ch0 grant ----------------
        evt_rdy = 1'b0;
        flip(2);
        tick(5);
        flip(0);
        tick(5);
        chk("sim_hold_ch", 32'(evt_ch), 32'h2);
        flip(0);
        tick(2);
        evt_rdy = 1'b1;
        tick(1);
        chk("sim_ev1_vld", 32'(evt_vld), 32'h1);
        chk("sim_ev1_ch", 32'(evt_ch), 32'h0);
        tick(1);
        chk("sim_ev2_vld", 32'(evt_vld), 32'h1);
        chk("sim_ev2_ch", 32'(evt_ch), 32'h0);
        tick(1);
        chk("sim_done", 32'(evt_vld), 32'h0);

        // ---------------- random run: 1000 paced toggles, random evt_rdy ----------------
        for (int c = 0; c < CH; c++) begin
            issued[c]    = 0;
            delivered[c] = 0;
        end
        total_iss = 0;
        cyc       = 0;
        while ((total_iss < 1000) && (cyc < 20000)) begin
            evt_rdy = ($urandom_range(0, 3) != 0);
            if (evt_vld && evt_rdy) begin
                if (issued[evt_ch] - delivered[evt_ch] <= 0)
                    chk("rnd_spurious", 32'(evt_ch), 32'hFF);
                delivered[evt_ch]++;
            end
            for (int c = 0; c < CH; c++) begin
                if ((ack_tgl[c] == tg[c]) && (issued[c] - delivered[c] < 5) &&
                    ($urandom_range(0, 1) == 1) && (total_iss < 1000)) begin
                    flip(c);
                    issued[c]++;
                    total_iss++;
                end
            end
            tick(1);
            cyc++;
        end
        chk("rnd_budget", 32'(total_iss), 32'd1000);
        evt_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (evt_vld) delivered[evt_ch]++;
            tick(1);
        end
        total_del = 0;
        for (int c = 0; c < CH; c++) begin
            chk("rnd_ch_count", 32'(delivered[c]), 32'(issued[c]));
            total_del += delivered[c];
        end
        chk("rnd_total", 32'(total_del), 32'(total_iss));
        chk("rnd_ack_final", 32'(ack_tgl), 32'(tg));
        chk("rnd_idle", 32'(evt_vld), 32'h0);
`ifdef PSYNC_OVF_EN
        chk("rnd_no_ovf", 32'(ovf), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
